// File: rtl/cache_tag_ary_nway_if.sv
// cache_tag_ary_nway_if: lookup, write and flush signals of the N-way tag array
// master: drives requests (flush, lookup, tag write) and receives status/response
// slave : the tag array side
interface cache_tag_ary_nway_if #(
    parameter int SETS  = 128,
    parameter int WAYS  = 2,
    parameter int TAG_W = 21
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    logic             i_flush;
    logic             o_busy;
    logic             i_lkp_vld;
    logic             o_lkp_rdy;
    logic [IDX_W-1:0] i_lkp_idx;
    logic [TAG_W-1:0] i_lkp_tag;
    logic             o_rsp_vld;
    logic             o_hit;
    logic [WAY_W-1:0] o_hit_way;
    logic [WAY_W-1:0] o_victim_way;
    logic             i_wen;
    logic [IDX_W-1:0] i_widx;
    logic [WAY_W-1:0] i_wway;
    logic [TAG_W-1:0] i_wtag;
    logic             i_wvld;
    modport master (
        output i_flush, i_lkp_vld, i_lkp_idx, i_lkp_tag, i_wen, i_widx, i_wway, i_wtag, i_wvld,
        input  o_busy, o_lkp_rdy, o_rsp_vld, o_hit, o_hit_way, o_victim_way
    );
    modport slave (
        input  i_flush, i_lkp_vld, i_lkp_idx, i_lkp_tag, i_wen, i_widx, i_wway, i_wtag, i_wvld,
        output o_busy, o_lkp_rdy, o_rsp_vld, o_hit, o_hit_way, o_victim_way
    );
endinterface

// File: rtl/cache_tag_ary_nway.sv
// cache_tag_ary_nway: set-associative tag/valid array with lookup, victim select and flush walk
// Ports: i_clk clock; i_rst async active-high reset; bus (slave modport) carries
//   flush/busy, lookup request (vld/rdy/idx/tag), registered response (rsp_vld/hit/hit_way/victim_way)
//   and tag write (wen/widx/wway/wtag/wvld).
// Macro CACHE_TAG_PLRU_EN selects per-set tree-PLRU replacement; otherwise a global round-robin counter.
module cache_tag_ary_nway #(
    parameter int SETS  = 128,
    parameter int WAYS  = 2,
    parameter int TAG_W = 21
) (
    input logic                  i_clk,
    input logic                  i_rst,
    cache_tag_ary_nway_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    logic [WAYS-1:0]  vld_q [SETS];
    logic [TAG_W-1:0] tag_q [SETS][WAYS];
    logic             busy_q;
    logic [IDX_W-1:0] cnt_q;
    logic             rsp_vld_q, hit_q;
    logic [WAY_W-1:0] hit_way_q, victim_q;
    logic             hit, has_inv, accept, wr;
    logic [WAY_W-1:0] hit_way, inv_way, pol_way;
    assign accept = bus.i_lkp_vld & ~busy_q;
    assign wr     = bus.i_wen & ~busy_q;
`ifdef CACHE_TAG_PLRU_EN
    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] plru_lkp, plru_wr;
    // tree bit 0 picks the half, bits 1/2 pick within the left/right pair
    function automatic logic [WAY_W-1:0] plru_vic(input logic [WAYS-2:0] p);
        logic [2:0] q;
        q = '0;
        q[WAYS-2:0] = p;
        return (WAYS == 2) ? WAY_W'(q[0]) : WAY_W'(q[0] ? {1'b1, q[2]} : {1'b0, q[1]});
    endfunction
    function automatic logic [WAYS-2:0] plru_upd(input logic [WAYS-2:0] p, input logic [WAY_W-1:0] w);
        logic [2:0] q;
        logic [1:0] v;
        q = '0;
        q[WAYS-2:0] = p;
        v = 2'(w);
        if (WAYS == 2) q[0] = ~v[0];
        else begin
            q[0] = ~v[1];
            if (v[1]) q[2] = ~v[0];
            else      q[1] = ~v[0];
        end
        return q[WAYS-2:0];
    endfunction
    assign pol_way  = plru_vic(plru_q[bus.i_lkp_idx]);
    assign plru_lkp = plru_upd(plru_q[bus.i_lkp_idx], hit_way);
    // a write to the set just hit builds on the hit's update so neither touch is lost
    assign plru_wr  = plru_upd((accept && hit && bus.i_widx == bus.i_lkp_idx) ? plru_lkp : plru_q[bus.i_widx], bus.i_wway);
`else
    logic [WAY_W-1:0] rr_q;
    assign pol_way = rr_q;
`endif
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        // descending scan so the lowest qualifying way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[bus.i_lkp_idx][w] && tag_q[bus.i_lkp_idx][w] == bus.i_lkp_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!vld_q[bus.i_lkp_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                vld_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
`ifdef CACHE_TAG_PLRU_EN
                plru_q[s] <= '0;
`endif
            end
`ifndef CACHE_TAG_PLRU_EN
            rr_q <= '0;
`endif
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= '0;
        end else begin
            // response is computed from pre-edge contents, giving read-before-write
            rsp_vld_q <= accept;
            hit_q     <= accept & hit;
            hit_way_q <= accept ? hit_way : '0;
            victim_q  <= accept ? (has_inv ? inv_way : pol_way) : '0;
            if (wr) begin
                vld_q[bus.i_widx][bus.i_wway] <= bus.i_wvld;
                tag_q[bus.i_widx][bus.i_wway] <= bus.i_wtag;
            end
`ifdef CACHE_TAG_PLRU_EN
            if (accept && hit) plru_q[bus.i_lkp_idx] <= plru_lkp;
            if (wr && bus.i_wvld) plru_q[bus.i_widx] <= plru_wr;
            if (busy_q) plru_q[cnt_q] <= '0;
`else
            if (wr && bus.i_wvld) rr_q <= rr_q + 1'b1;
`endif
            if (busy_q) begin
                vld_q[cnt_q] <= '0;
                cnt_q        <= cnt_q + 1'b1;
                busy_q       <= cnt_q != IDX_W'(SETS - 1);
            end else if (bus.i_flush) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
            end
        end
    end
    assign bus.o_busy       = busy_q;
    assign bus.o_lkp_rdy    = ~busy_q;
    assign bus.o_rsp_vld    = rsp_vld_q;
    assign bus.o_hit        = hit_q;
    assign bus.o_hit_way    = hit_way_q;
    assign bus.o_victim_way = victim_q;
endmodule

// File: tb/tb_cache_tag_ary_nway.sv
// tb_cache_tag_ary_nway: directed plus randomized checks of the tag array against a behavioural model
module tb_cache_tag_ary_nway;
    localparam int SETS  = 128;
    localparam int WAYS  = 2;
    localparam int TAG_W = 21;
`ifdef CACHE_TAG_PLRU_EN
    localparam int PLRU = 1;
`else
    localparam int PLRU = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    cache_tag_ary_nway_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();
    cache_tag_ary_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
    // behavioural model: plain arrays of valid/tag, remaining flush cycles, policy state
    bit               mv [SETS][WAYS];
    logic [TAG_W-1:0] mt [SETS][WAYS];
    int               mru [SETS];
    int               mrr;
    int               flush_left;
    bit               e_rsp, e_hit;
    int               e_hw, e_vic;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                mru[s] = WAYS - 1;
                for (int w = 0; w < WAYS; w++) begin
                    mv[s][w] = 0;
                    mt[s][w] = '0;
                end
            end
            mrr = 0;
            flush_left = 0;
            e_rsp = 0;
        end else begin
            e_rsp = bus.i_lkp_vld && flush_left == 0;
            if (e_rsp) begin
                e_hit = 0;
                e_hw = 0;
                e_vic = -1;
                for (int w = 0; w < WAYS; w++) begin
                    if (!e_hit && mv[bus.i_lkp_idx][w] && mt[bus.i_lkp_idx][w] == bus.i_lkp_tag) begin
                        e_hit = 1;
                        e_hw = w;
                    end
                    if (e_vic < 0 && !mv[bus.i_lkp_idx][w]) e_vic = w;
                end
                if (e_vic < 0) e_vic = PLRU ? (WAYS - 1 - mru[bus.i_lkp_idx]) : mrr;
                if (e_hit) mru[bus.i_lkp_idx] = e_hw;
            end
            if (flush_left > 0) begin
                for (int w = 0; w < WAYS; w++) mv[SETS - flush_left][w] = 0;
                mru[SETS - flush_left] = WAYS - 1;
                flush_left--;
            end else begin
                if (bus.i_wen) begin
                    mv[bus.i_widx][bus.i_wway] = bus.i_wvld;
                    mt[bus.i_widx][bus.i_wway] = bus.i_wtag;
                    if (bus.i_wvld) begin
                        mrr = (mrr + 1) % WAYS;
                        mru[bus.i_widx] = bus.i_wway;
                    end
                end
                if (bus.i_flush) flush_left = SETS;
            end
        end
    end
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(bus.o_busy), 32'(flush_left > 0));
            chk("lkp_rdy", 32'(bus.o_lkp_rdy), 32'(flush_left == 0));
            chk("rsp_vld", 32'(bus.o_rsp_vld), 32'(e_rsp));
            if (e_rsp) begin
                chk("hit", 32'(bus.o_hit), 32'(e_hit));
                chk("hit_way", 32'(bus.o_hit_way), 32'(e_hw));
                chk("victim", 32'(bus.o_victim_way), 32'(e_vic));
            end
        end
    end
    task automatic idle();
        bus.i_flush = 0;
        bus.i_lkp_vld = 0;
        bus.i_wen = 0;
    endtask
    task automatic lookup(input int idx, input logic [TAG_W-1:0] tag);
        bus.i_lkp_vld = 1;
        bus.i_lkp_idx = 7'(idx);
        bus.i_lkp_tag = tag;
        @(negedge clk);
        bus.i_lkp_vld = 0;
    endtask
    task automatic write(input int idx, input int way, input logic [TAG_W-1:0] tag, input bit v);
        bus.i_wen = 1;
        bus.i_widx = 7'(idx);
        bus.i_wway = 1'(way);
        bus.i_wtag = tag;
        bus.i_wvld = v;
        @(negedge clk);
        bus.i_wen = 0;
    endtask
    task automatic wait_idle(input string n);
        int k = 0;
        while (bus.o_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk(n, 32'(bus.o_busy), 32'd0);
    endtask
    initial begin
        int n;
        bit rdy_bad;
        idle();
        bus.i_lkp_idx = '0;
        bus.i_lkp_tag = '0;
        bus.i_widx = '0;
        bus.i_wway = '0;
        bus.i_wtag = '0;
        bus.i_wvld = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_rsp_vld", 32'(bus.o_rsp_vld), 32'd0);
        chk("rst_hit", 32'(bus.o_hit), 32'd0);
        chk("rst_hit_way", 32'(bus.o_hit_way), 32'd0);
        chk("rst_victim", 32'(bus.o_victim_way), 32'd0);
        rst = 0;
        @(negedge clk);
        lookup(5, 21'h1A);
        chk("cold_rsp_vld", 32'(bus.o_rsp_vld), 32'd1);
        chk("cold_hit", 32'(bus.o_hit), 32'd0);
        chk("cold_victim", 32'(bus.o_victim_way), 32'd0);
        write(5, 1, 21'h1A, 1);
        lookup(5, 21'h1A);
        chk("w1_hit", 32'(bus.o_hit), 32'd1);
        chk("w1_hit_way", 32'(bus.o_hit_way), 32'd1);
        chk("w1_victim", 32'(bus.o_victim_way), 32'd0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        write(3, 0, 21'h11, 1);
        write(3, 1, 21'h22, 1);
        lookup(3, 21'h11);
        chk("full_hit", 32'(bus.o_hit), 32'd1);
        chk("full_hit_way", 32'(bus.o_hit_way), 32'd0);
        lookup(3, 21'h33);
        chk("full_miss", 32'(bus.o_hit), 32'd0);
        chk("full_victim", 32'(bus.o_victim_way), PLRU ? 32'd1 : 32'd0);
        write(7, 0, 21'h5, 1);
        bus.i_flush = 1;
        @(negedge clk);
        bus.i_flush = 0;
        n = 0;
        rdy_bad = 0;
        while (bus.o_busy && n < 1000) begin
            if (bus.o_lkp_rdy) rdy_bad = 1;
            n++;
            if (n == 50) bus.i_flush = 1;
            @(negedge clk);
            bus.i_flush = 0;
        end
        chk("flush_cycles", 32'(n), 32'd128);
        chk("flush_rdy_low", 32'(rdy_bad), 32'd0);
        lookup(7, 21'h5);
        chk("post_flush_7", 32'(bus.o_hit), 32'd0);
        lookup(3, 21'h11);
        chk("post_flush_3", 32'(bus.o_hit), 32'd0);
        write(9, 1, 21'h77, 1);
        bus.i_flush = 1;
        lookup(9, 21'h77);
        bus.i_flush = 0;
        chk("flush_lkp_hit", 32'(bus.o_hit), 32'd1);
        chk("flush_lkp_way", 32'(bus.o_hit_way), 32'd1);
        wait_idle("flush_lkp_idle");
        lookup(9, 21'h77);
        chk("flush_lkp_after", 32'(bus.o_hit), 32'd0);
        write(12, 0, 21'h0, 1);
        bus.i_flush = 1;
        @(negedge clk);
        bus.i_flush = 0;
        repeat (10) @(negedge clk);
        rst = 1;
        #1;
        chk("abort_busy", 32'(bus.o_busy), 32'd0);
        chk("abort_rdy", 32'(bus.o_lkp_rdy), 32'd1);
        @(negedge clk);
        rst = 0;
        for (int s = 0; s < SETS; s++) begin
            lookup(s, 21'h0);
            chk("abort_miss", 32'(bus.o_hit), 32'd0);
        end
        for (int c = 0; c < 3000; c++) begin
            bus.i_lkp_vld = $urandom_range(0, 1) == 1;
            bus.i_lkp_idx = 7'($urandom_range(0, 7));
            bus.i_lkp_tag = 21'($urandom_range(0, 3));
            bus.i_wen = $urandom_range(0, 2) == 0;
            bus.i_widx = 7'($urandom_range(0, 7));
            bus.i_wway = 1'($urandom_range(0, 1));
            bus.i_wtag = 21'($urandom_range(0, 3));
            bus.i_wvld = $urandom_range(0, 4) != 0;
            bus.i_flush = $urandom_range(0, 199) == 0;
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
